// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into instruction words,
// writes them from address 0 and holds the core in reset until the load is done.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;
  typedef enum logic [2:0] {HDR, DATA, WRITE, DONE, ERR} state_t;
  state_t state;
  logic [1:0] idx;
  logic [31:0] word;
  logic [31:0] full;
  logic [ADDR_WIDTH:0] cnt;
  logic [ADDR_WIDTH:0] wl_next;
  logic take;
  assign take = in_valid && in_ready;
  // header and data words share one shift register; bytes enter at the top so byte0 lands in 7:0
  assign full = {in_data, word[31:8]};
  assign wl_next = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign in_ready = state == HDR || state == DATA;
  assign mem_we = state == WRITE;
  assign mem_addr = words_loaded[ADDR_WIDTH-1:0];
  assign mem_wdata = word;
  assign done = state == DONE;
  assign error = state == ERR;
  assign cpu_rst_n = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HDR;
      idx <= 2'd0;
      word <= 32'd0;
      cnt <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        HDR: if (take) begin
          idx <= idx + 2'd1;
          word <= full;
          if (idx == 2'd3) begin
            cnt <= full[ADDR_WIDTH:0];
            state <= full == 32'd0 ? DONE : full > DEPTH ? ERR : DATA;
          end
        end
        DATA: if (take) begin
          idx <= idx + 2'd1;
          word <= full;
          if (idx == 2'd3) state <= WRITE;
        end
        WRITE: begin
          words_loaded <= wl_next;
          state <= wl_next == cnt ? DONE : DATA;
        end
        DONE, ERR: if (reload) begin
          state <= HDR;
          idx <= 2'd0;
          word <= 32'd0;
          cnt <= '0;
          words_loaded <= '0;
        end
        default: state <= HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized loads checked against a stream-level model of the loader.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = 8'd0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic reload = 1'b0;
  logic mem_we;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata;
  logic cpu_rst_n;
  logic done;
  logic error;
  logic [10:0] words_loaded;
  int errs = 0;
  int chks = 0;
  logic [31:0] ew [1024];
  int wq_addr[$];
  logic [31:0] wq_data[$];
  logic prev_we = 1'b0;

  imem_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // write monitor: every strobe is logged and must last a single cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(int'(mem_addr));
      wq_data.push_back(mem_wdata);
      chks++;
      if (prev_we) begin
        errs++;
        $display("FAIL we_pulse: mem_we high %0d consecutive cycles, required 1", 2);
      end
    end
    prev_we <= mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input int gmax);
    int t = 0;
    repeat ($urandom_range(gmax, 0)) @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chks++;
    if (t >= 200) begin
      errs++;
      $display("FAIL handshake: in_ready=%0b after %0d cycles, required 1", in_ready, t);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drives header n followed by the first n words of ew (if n is legal) and checks the outcome
  task automatic do_load(input logic [31:0] n, input int gmax);
    int nw;
    wq_addr.delete();
    wq_data.delete();
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gmax);
    nw = (n > 32'd1024) ? 0 : int'(n);
    if (n == 32'd0 || n > 32'd1024) begin
      chks++;
      if (done !== (n == 32'd0) || error !== (n != 32'd0) || cpu_rst_n !== (n == 32'd0) || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL hdr_end n=%0d: done=%0b error=%0b cpu_rst_n=%0b in_ready=%0b, required %0b %0b %0b 0",
                 n, done, error, cpu_rst_n, in_ready, n == 32'd0, n != 32'd0, n == 32'd0);
      end
      repeat (3) @(negedge clk);
      chks++;
      if (in_ready !== 1'b0 || done !== (n == 32'd0) || error !== (n != 32'd0)) begin
        errs++;
        $display("FAIL hold n=%0d: in_ready=%0b done=%0b error=%0b", n, in_ready, done, error);
      end
    end
    for (int i = 0; i < nw; i++) begin
      for (int k = 0; k < 4; k++) send_byte(ew[i][8*k +: 8], gmax);
      chks++;
      if (mem_we !== 1'b1 || int'(mem_addr) != i || mem_wdata !== ew[i] || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL write %0d: we=%0b addr=%0d data=%h in_ready=%0b, required 1 %0d %h 0",
                 i, mem_we, mem_addr, mem_wdata, in_ready, i, ew[i]);
      end
      if (i < nw - 1) begin
        chks++;
        if (done !== 1'b0 || cpu_rst_n !== 1'b0) begin
          errs++;
          $display("FAIL early_done %0d: done=%0b cpu_rst_n=%0b, required 0 0", i, done, cpu_rst_n);
        end
      end
    end
    if (nw > 0) begin
      @(negedge clk);
      chks++;
      if (done !== 1'b1 || cpu_rst_n !== 1'b1 || mem_we !== 1'b0 || int'(words_loaded) != nw) begin
        errs++;
        $display("FAIL finish: done=%0b cpu_rst_n=%0b we=%0b words_loaded=%0d, required 1 1 0 %0d",
                 done, cpu_rst_n, mem_we, words_loaded, nw);
      end
    end
    chks++;
    if (wq_addr.size() != nw) begin
      errs++;
      $display("FAIL write_count: %0d writes, required %0d", wq_addr.size(), nw);
    end else begin
      for (int i = 0; i < nw; i++) begin
        chks++;
        if (wq_addr[i] != i || wq_data[i] !== ew[i]) begin
          errs++;
          $display("FAIL logged_write %0d: addr=%0d data=%h, required %0d %h", i, wq_addr[i], wq_data[i], i, ew[i]);
        end
      end
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chks++;
    if (done !== 1'b0 || error !== 1'b0 || cpu_rst_n !== 1'b0 || words_loaded !== 11'd0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reload: done=%0b error=%0b cpu_rst_n=%0b words_loaded=%0d in_ready=%0b, required 0 0 0 0 1",
               done, error, cpu_rst_n, words_loaded, in_ready);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0 ||
        cpu_rst_n !== 1'b0 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 11'd0) begin
      errs++;
      $display("FAIL %s: rdy=%0b we=%0b addr=%0d wdata=%h cpu_rst_n=%0b done=%0b error=%0b wl=%0d, required 1 0 0 0 0 0 0 0",
               tag, in_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, done, error, words_loaded);
    end
  endtask

  task automatic test_reset();
    #2;
    check_reset_values("reset_state");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ew[0] = 32'h00500093;
    ew[1] = 32'h00A00113;
    do_load(32'd2, 0);
  endtask

  task automatic test_zero();
    do_load(32'd0, 0);
  endtask

  task automatic test_oversize();
    do_load(32'd1025, 0);
    do_reload();
    do_load(32'h0100_0000, 1);
    do_reload();
  endtask

  task automatic test_gaps();
    ew[0] = 32'h002081B3;
    do_load(32'd1, 5);
  endtask

  task automatic test_random();
    int n = $urandom_range(8, 3);
    for (int i = 0; i < n; i++) ew[i] = $urandom;
    do_load(n, 3);
  endtask

  task automatic test_reset_mid();
    ew[0] = 32'hDEADBEEF;
    ew[1] = 32'h12345678;
    for (int k = 0; k < 4; k++) send_byte(k == 0 ? 8'd2 : 8'd0, 0);
    for (int k = 0; k < 4; k++) send_byte(ew[0][8*k +: 8], 0);
    send_byte(ew[1][7:0], 0);
    send_byte(ew[1][15:8], 0);
    #2 rst = 1'b1;
    #1;
    check_reset_values("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    ew[0] = 32'hCAFEF00D;
    do_load(32'd1, 1);
  endtask

  task automatic test_full();
    for (int i = 0; i < 1024; i++) ew[i] = 32'h1000_0000 + i;
    do_load(32'd1024, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    do_reload();
    test_zero();
    do_reload();
    test_oversize();
    test_gaps();
    do_reload();
    test_random();
    do_reload();
    test_reset_mid();
    do_reload();
    test_full();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
